game_flow_controller: RTL

Top-level sequencer for the physics engine. It issues the physics engine's per-frame START_UPDATE and drives its RESET. It tracks lives and counts remaining blocks by serially scanning a per-frame snapshot of BLOCK_STATE. It runs the serve / play / ball-lost / game-over / level-clear flow between the VGA frame timing and the physics block.

---
 rtl/game_flow_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/game_flow_controller.sv
// game_flow_controller: serve/play/lost/over/clear sequencer with serial block-count scan.
// Optional pause (macro PAUSE_EN) adds BTN_PAUSE and reports GAME_STATE 6 while paused.
module game_flow_controller #(
    parameter int LIVES_INIT        = 3,
    parameter int PHYS_RESET_CYCLES = 4,
    parameter int LOST_DELAY_FRAMES = 60,
    parameter int BLOCK_COUNT       = 72
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   FRAME_TICK,
    input  logic                   BTN_RELEASE,
    input  logic                   BALL_LOST,
    input  logic [BLOCK_COUNT-1:0] BLOCK_STATE,
`ifdef PAUSE_EN
    input  logic                   BTN_PAUSE,
`endif
    output logic                   PHYS_RESET,
    output logic                   START_UPDATE,
    output logic [1:0]             LIVES,
    output logic [6:0]             BLOCKS_LEFT,
    output logic [2:0]             GAME_STATE,
    output logic                   GAME_OVER,
    output logic                   LEVEL_CLEAR
);
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_LOST  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_CLEAR = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [1:0]             lives_q, lives_d;
    logic [3:0]             rst_cnt_q, rst_cnt_d;
    logic [7:0]             lost_cnt_q, lost_cnt_d;
    logic [BLOCK_COUNT-1:0] sh_q, sh_d;
    logic [6:0]             acc_q, acc_d;
    logic [6:0]             scan_cnt_q, scan_cnt_d;
    logic [6:0]             blocks_q, blocks_d;
    logic                   done_q, done_d;
    logic                   start_q, start_d;
    logic                   btn_q;
    logic                   rel_rise, paused, in_rst, busy;
`ifdef PAUSE_EN
    logic                   pause_q, pause_d, pbtn_q;
`endif

    always_comb begin
        rel_rise   = BTN_RELEASE & ~btn_q;
`ifdef PAUSE_EN
        paused     = pause_q;
`else
        paused     = 1'b0;
`endif
        state_d    = state_q;
        lives_d    = lives_q;
        rst_cnt_d  = '0;
        lost_cnt_d = '0;
        case (state_q)
            S_RESET: begin
                rst_cnt_d = rst_cnt_q + 4'd1;
                if (rst_cnt_q == 4'(PHYS_RESET_CYCLES - 1)) state_d = S_SERVE;
            end
            S_SERVE: if (BTN_RELEASE) state_d = S_PLAY;
            S_PLAY: if (!paused) begin
                if (done_q && blocks_q == 7'd0) state_d = S_CLEAR;
                else if (BALL_LOST) begin
                    state_d = S_LOST;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end
            end
            S_LOST: begin
                lost_cnt_d = lost_cnt_q + {7'd0, FRAME_TICK};
                if (FRAME_TICK && lost_cnt_q == 8'(LOST_DELAY_FRAMES - 1)) begin
                    lost_cnt_d = '0;
                    state_d    = (lives_q == 2'd0) ? S_OVER : S_RESET;
                end
            end
            S_OVER: if (rel_rise) begin
                state_d = S_RESET;
                lives_d = 2'(LIVES_INIT);
            end
            S_CLEAR: if (rel_rise) state_d = S_RESET;
            default: state_d = S_RESET;
        endcase
        start_d    = FRAME_TICK && (state_q == S_SERVE || state_q == S_PLAY) && !paused;
        // Entering or sitting in RESET aborts the scan so a stale zero count cannot trigger CLEAR
        in_rst     = (state_q == S_RESET) || (state_d == S_RESET);
        busy       = scan_cnt_q != 7'd0;
        sh_d       = busy ? sh_q >> 1 : sh_q;
        acc_d      = busy ? acc_q + {6'd0, sh_q[0]} : acc_q;
        scan_cnt_d = busy ? scan_cnt_q - 7'd1 : scan_cnt_q;
        done_d     = scan_cnt_q == 7'd1;
        blocks_d   = done_d ? acc_d : blocks_q;
        if (in_rst) begin
            scan_cnt_d = '0;
            done_d     = 1'b0;
            blocks_d   = 7'(BLOCK_COUNT);
        end else if (FRAME_TICK) begin
            sh_d       = BLOCK_STATE;
            acc_d      = '0;
            scan_cnt_d = 7'(BLOCK_COUNT);
            done_d     = 1'b0;
            blocks_d   = blocks_q;
        end
`ifdef PAUSE_EN
        pause_d    = (state_q == S_PLAY) && (state_d == S_PLAY) && (pause_q ^ (BTN_PAUSE & ~pbtn_q));
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_RESET;
            lives_q    <= 2'(LIVES_INIT);
            rst_cnt_q  <= '0;
            lost_cnt_q <= '0;
            sh_q       <= '0;
            acc_q      <= '0;
            scan_cnt_q <= '0;
            blocks_q   <= 7'(BLOCK_COUNT);
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            btn_q      <= 1'b0;
`ifdef PAUSE_EN
            pause_q    <= 1'b0;
            pbtn_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            rst_cnt_q  <= rst_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            scan_cnt_q <= scan_cnt_d;
            blocks_q   <= blocks_d;
            done_q     <= done_d;
            start_q    <= start_d;
            btn_q      <= BTN_RELEASE;
`ifdef PAUSE_EN
            pause_q    <= pause_d;
            pbtn_q     <= BTN_PAUSE;
`endif
        end
    end

    assign PHYS_RESET   = state_q == S_RESET;
    assign START_UPDATE = start_q;
    assign LIVES        = lives_q;
    assign BLOCKS_LEFT  = blocks_q;
    assign GAME_STATE   = paused ? 3'd6 : state_q;
    assign GAME_OVER    = state_q == S_OVER;
    assign LEVEL_CLEAR  = state_q == S_CLEAR;
endmodule
